// File: rtl/dmac_pkg.sv
// Shared types and constants for the DMA read scheduler slice.
//   dmac_rd_sched_state_e : scheduler FSM states
//   dmac_rd_ctx_t         : per-channel read context (addr, length, burst, size)
//   CH_ID_WD              : channel index width for the default channel count
package dmac_pkg;

   localparam int unsigned DMAC_ADDR_WD       = 32;
   localparam int unsigned DMAC_CHANNEL_COUNT = 8;
   localparam int unsigned CH_ID_WD           = $clog2(DMAC_CHANNEL_COUNT);

   typedef enum logic [1:0] {
      IDLE,
      ARB,
      ISSUE
   } dmac_rd_sched_state_e;

   typedef struct packed {
      logic [DMAC_ADDR_WD-1:0] addr;
      logic [DMAC_ADDR_WD-1:0] length;
      logic [1:0]              burst;
      logic [2:0]              size;
   } dmac_rd_ctx_t;

endpackage

// File: rtl/dmac_rr_arbiter.sv
// Combinational round-robin arbiter.
//   req         : request bitmap
//   ptr         : index of the last granted requester; search starts at ptr+1 and wraps
//   grant_valid : at least one request present
//   grant_idx   : index of the winning requester
module dmac_rr_arbiter #(
   parameter int unsigned N = 8,
   localparam int unsigned IDX_WD = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]      req,
   input  logic [IDX_WD-1:0] ptr,
   output logic              grant_valid,
   output logic [IDX_WD-1:0] grant_idx
);

   // Scan from the farthest position back to the nearest one so the last hit
   // (closest to ptr+1) wins; ptr itself has the lowest priority.
   always_comb begin
      grant_valid = 1'b0;
      grant_idx   = '0;
      for (int i = int'(N); i >= 1; i--) begin
         int idx;
         idx = (int'(ptr) + i) % int'(N);
         if (req[idx]) begin
            grant_valid = 1'b1;
            grant_idx   = IDX_WD'(idx);
         end
      end
   end

endmodule

// File: rtl/dmac_read_scheduler.sv
// Per-channel read-context store and round-robin burst scheduler feeding the read initiator.
//   clk, rst_n            : clock, asynchronous active-low reset
//   cfg_*                 : channel start request (cfg_ready low while the channel is active)
//   ch_busy, ch_done      : active bitmap, one-cycle completion pulses
//   rd_req_*              : one burst request at a time to the initiator, held until rd_req_ack
//   rd_req_next_*/done    : context write-back values, sampled on ack
//   rd_burst_done         : R-channel last beat, returns one in-flight credit
module dmac_read_scheduler
   import dmac_pkg::*;
#(
   parameter int unsigned ADDR_WD         = DMAC_ADDR_WD,
   parameter int unsigned CHANNEL_COUNT   = DMAC_CHANNEL_COUNT,
   parameter int unsigned MAX_OUTSTANDING = 4,
   localparam int unsigned CH_W = (CHANNEL_COUNT > 1) ? $clog2(CHANNEL_COUNT) : 1
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     cfg_valid,
   output logic                     cfg_ready,
   input  logic [CH_W-1:0]          cfg_ch,
   input  logic [ADDR_WD-1:0]       cfg_addr,
   input  logic [ADDR_WD-1:0]       cfg_length,
   input  logic [1:0]               cfg_burst,
   input  logic [2:0]               cfg_size,
   output logic [CHANNEL_COUNT-1:0] ch_busy,
   output logic [CHANNEL_COUNT-1:0] ch_done,
   output logic                     rd_req_valid,
   output logic [CH_W-1:0]          rd_req_ch,
   output logic [ADDR_WD-1:0]       rd_req_addr,
   output logic [1:0]               rd_req_burst,
   output logic [ADDR_WD-1:0]       rd_req_length,
   output logic [2:0]               rd_req_size,
   input  logic                     rd_req_ack,
   input  logic [ADDR_WD-1:0]       rd_req_next_addr,
   input  logic [ADDR_WD-1:0]       rd_req_next_length,
   input  logic                     rd_req_done,
   input  logic                     rd_burst_done
);

   localparam int unsigned CRED_WD = $clog2(MAX_OUTSTANDING + 1);
   localparam logic [CRED_WD-1:0] CRED_MAX = CRED_WD'(MAX_OUTSTANDING);

   dmac_rd_sched_state_e state_q, state_d;
   dmac_rd_ctx_t         ctx_q [CHANNEL_COUNT];
   dmac_rd_ctx_t         ctx_d [CHANNEL_COUNT];

   logic [CHANNEL_COUNT-1:0] active_q, active_d;
   logic [CHANNEL_COUNT-1:0] ch_done_q, ch_done_d;
   logic [CRED_WD-1:0]       credits_q, credits_d;
   logic [CH_W-1:0]          rr_ptr_q, rr_ptr_d;

   logic               req_valid_q, req_valid_d;
   logic [CH_W-1:0]    req_ch_q, req_ch_d;
   logic [ADDR_WD-1:0] req_addr_q, req_addr_d;
   logic [1:0]         req_burst_q, req_burst_d;
   logic [ADDR_WD-1:0] req_length_q, req_length_d;
   logic [2:0]         req_size_q, req_size_d;

   logic            grant_valid;
   logic [CH_W-1:0] grant_idx;
   logic            cfg_fire;
   logic            ack_fire;

   dmac_rr_arbiter #(
      .N (CHANNEL_COUNT)
   ) u_arb (
      .req         (active_q),
      .ptr         (rr_ptr_q),
      .grant_valid (grant_valid),
      .grant_idx   (grant_idx)
   );

   assign cfg_ready = ~active_q[cfg_ch];
   assign cfg_fire  = cfg_valid & cfg_ready;
   assign ack_fire  = (state_q == ISSUE) & rd_req_ack;

   always_comb begin
      state_d      = state_q;
      ctx_d        = ctx_q;
      active_d     = active_q;
      ch_done_d    = '0;
      credits_d    = credits_q;
      rr_ptr_d     = rr_ptr_q;
      req_valid_d  = req_valid_q;
      req_ch_d     = req_ch_q;
      req_addr_d   = req_addr_q;
      req_burst_d  = req_burst_q;
      req_length_d = req_length_q;
      req_size_d   = req_size_q;

      // A config can only target an inactive channel, so it never collides with
      // the channel being arbitrated or issued.
      if (cfg_fire) begin
         ctx_d[cfg_ch].addr   = DMAC_ADDR_WD'(cfg_addr);
         ctx_d[cfg_ch].length = DMAC_ADDR_WD'(cfg_length);
         ctx_d[cfg_ch].burst  = cfg_burst;
         ctx_d[cfg_ch].size   = cfg_size;
         if (cfg_length == '0) begin
            ch_done_d[cfg_ch] = 1'b1;
         end else begin
            active_d[cfg_ch] = 1'b1;
         end
      end

      unique case (state_q)
         IDLE: begin
            if ((|active_q) && (credits_q != '0)) begin
               state_d = ARB;
            end
         end
         ARB: begin
            if (grant_valid) begin
               req_valid_d  = 1'b1;
               req_ch_d     = grant_idx;
               req_addr_d   = ADDR_WD'(ctx_q[grant_idx].addr);
               req_burst_d  = ctx_q[grant_idx].burst;
               req_length_d = ADDR_WD'(ctx_q[grant_idx].length);
               req_size_d   = ctx_q[grant_idx].size;
               state_d      = ISSUE;
            end else begin
               state_d = IDLE;
            end
         end
         ISSUE: begin
            if (rd_req_ack) begin
               ctx_d[req_ch_q].addr   = DMAC_ADDR_WD'(rd_req_next_addr);
               ctx_d[req_ch_q].length = DMAC_ADDR_WD'(rd_req_next_length);
               rr_ptr_d               = req_ch_q;
               req_valid_d            = 1'b0;
               if (rd_req_done) begin
                  active_d[req_ch_q]  = 1'b0;
                  ch_done_d[req_ch_q] = 1'b1;
               end
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      // Issue and return in the same cycle cancel out; a return with nothing
      // outstanding is dropped.
      case ({ack_fire, rd_burst_done})
         2'b10: credits_d = credits_q - CRED_WD'(1);
         2'b01: begin
            if (credits_q < CRED_MAX) begin
               credits_d = credits_q + CRED_WD'(1);
            end
         end
         default: credits_d = credits_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         active_q     <= '0;
         ch_done_q    <= '0;
         credits_q    <= CRED_MAX;
         rr_ptr_q     <= '0;
         req_valid_q  <= 1'b0;
         req_ch_q     <= '0;
         req_addr_q   <= '0;
         req_burst_q  <= '0;
         req_length_q <= '0;
         req_size_q   <= '0;
         for (int i = 0; i < int'(CHANNEL_COUNT); i++) begin
            ctx_q[i] <= '0;
         end
      end else begin
         state_q      <= state_d;
         active_q     <= active_d;
         ch_done_q    <= ch_done_d;
         credits_q    <= credits_d;
         rr_ptr_q     <= rr_ptr_d;
         req_valid_q  <= req_valid_d;
         req_ch_q     <= req_ch_d;
         req_addr_q   <= req_addr_d;
         req_burst_q  <= req_burst_d;
         req_length_q <= req_length_d;
         req_size_q   <= req_size_d;
         for (int i = 0; i < int'(CHANNEL_COUNT); i++) begin
            ctx_q[i] <= ctx_d[i];
         end
      end
   end

   // A credit return with no burst outstanding indicates an upstream bookkeeping error.
   credit_overflow_chk: assert property (@(posedge clk) disable iff (!rst_n)
      !(rd_burst_done && !ack_fire && (credits_q == CRED_MAX)));

   assign ch_busy       = active_q;
   assign ch_done       = ch_done_q;
   assign rd_req_valid  = req_valid_q;
   assign rd_req_ch     = req_ch_q;
   assign rd_req_addr   = req_addr_q;
   assign rd_req_burst  = req_burst_q;
   assign rd_req_length = req_length_q;
   assign rd_req_size   = req_size_q;

endmodule
